// File: rtl/seven_seg_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_pkg
// Shared types and constants for the 4-digit common-anode 7-segment display
// path.
//   state_t       : scanner FSM states (BLANK dead time, SHOW digit lit)
//   SEG_OFF       : all segments dark (active-low)
//   AN_OFF        : all anodes disabled (active-low)
//   HEX_SEG       : 16-entry hex -> segment table, active-low, written
//                   left-to-right as a..g (bit 6 = a ... bit 0 = g)
//   lead_zero_mask: which digits are leading zeros of a 4-nibble value
// ---------------------------------------------------------------------------
package seven_seg_pkg;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Active-low patterns, a..g left to right.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4  (b c f g)
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  // Bit i is set when nibble i and every higher nibble are zero.
  // Digit 0 is always shown so a value of zero still reads "0".
  function automatic logic [3:0] lead_zero_mask(input logic [15:0] nibbles);
    logic [3:0] mask;
    mask[3] = (nibbles[15:12] == 4'h0);
    mask[2] = mask[3] & (nibbles[11:8] == 4'h0);
    mask[1] = mask[2] & (nibbles[7:4] == 4'h0);
    mask[0] = 1'b0;
    return mask;
  endfunction

  // One-hot active-low anode select for a 2-bit digit index.
  function automatic logic [3:0] anode_select(input logic [1:0] digit);
    return ~(4'b0001 << digit);
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// ---------------------------------------------------------------------------
// hex_to_seg
// Combinational hex nibble to active-low 7-segment pattern. Kept as its own
// module so the single-digit display path can reuse the same decoder.
// Ports:
//   nibble  in  4  hex value 0..F
//   seg     out 7  active-low segments, bit 6 = a ... bit 0 = g
// ---------------------------------------------------------------------------
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern.
  always_comb begin
    seg = HEX_SEG[nibble];
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
// Autonomous time-multiplexed driver for a 4-digit common-anode 7-segment
// display. Each digit gets BLANK_CYC cycles of dead time (all anodes off)
// followed by REFRESH_DIV cycles lit. The inputs are snapshotted on the first
// cycle of every frame, so a frame never mixes old and new data.
//
// Parameters:
//   REFRESH_DIV  lit time per digit in clk cycles (>= 1)
//   BLANK_CYC    dead time before each digit in clk cycles (>= 1)
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits 1..3 are also
//                          blanked (decided from the snapshot)
// Ports:
//   clk       in   1   system clock, rising edge
//   rst_n     in   1   synchronous reset, active-low
//   digits_i  in   16  hex nibbles, [3:0] = digit 0 (rightmost)
//   dp_i      in   4   decimal point request per digit, 1 = lit
//   blank_i   in   4   force digit off, 1 = blank
//   AN        out  4   anode enables, active-low, AN[i] = digit i
//   D         out  7   segments, active-low, bit 6 = a ... bit 0 = g
//   DP        out  1   decimal point, active-low
// All outputs are registered and follow the FSM state with one cycle of
// latency.
// ---------------------------------------------------------------------------
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits_i,
  input  logic [3:0]  dp_i,
  input  logic [3:0]  blank_i,
  output logic [3:0]  AN,
  output logic [6:0]  D,
  output logic        DP
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       idx;
  logic [1:0]       idx_next;

  logic [15:0]      snap_digits;
  logic [3:0]       snap_dp;
  logic [3:0]       snap_blank;
  logic [3:0]       blank_in;
  logic             snap_en;

  logic [3:0]       cur_nibble;
  logic [6:0]       cur_seg;

  logic [3:0]       an_next;
  logic [6:0]       d_next;
  logic             dp_next;

  // The frame starts on the first dead-time cycle of digit 0.
  assign snap_en = (state == BLANK) && (idx == 2'd0) && (cnt == '0);

  // Blank mask captured into the snapshot, optionally including leading zeros.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    blank_in = blank_i | lead_zero_mask(digits_i);
`else
    blank_in = blank_i;
`endif
  end

  // Snapshot registers: loaded once per frame, held otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_digits <= 16'h0000;
      snap_dp     <= 4'b0000;
      snap_blank  <= 4'b0000;
    end else if (snap_en) begin
      snap_digits <= digits_i;
      snap_dp     <= dp_i;
      snap_blank  <= blank_in;
    end else begin
      snap_digits <= snap_digits;
      snap_dp     <= snap_dp;
      snap_blank  <= snap_blank;
    end
  end

  // Next-state logic: dead time then lit time per digit, digit index wraps.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CNT_W'(1);
    idx_next   = idx;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_next = SHOW;
          cnt_next   = '0;
        end else begin
          state_next = BLANK;
        end
      end
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_next = BLANK;
          cnt_next   = '0;
          idx_next   = idx + 2'd1;
        end else begin
          state_next = SHOW;
        end
      end
      default: begin
        state_next = BLANK;
        cnt_next   = '0;
        idx_next   = 2'd0;
      end
    endcase
  end

  // FSM state, dwell counter and digit index registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
    end
  end

  // Nibble of the digit currently being scanned, from the snapshot only.
  assign cur_nibble = snap_digits[{idx, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // Output values for the current state; a blanked digit keeps its time slot
  // but leaves everything dark.
  always_comb begin
    an_next = AN_OFF;
    d_next  = SEG_OFF;
    dp_next = 1'b1;
    if ((state == SHOW) && !snap_blank[idx]) begin
      an_next = anode_select(idx);
      d_next  = cur_seg;
      dp_next = ~snap_dp[idx];
    end else begin
      an_next = AN_OFF;
      d_next  = SEG_OFF;
      dp_next = 1'b1;
    end
  end

  // Registered display pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      AN <= AN_OFF;
      D  <= SEG_OFF;
      DP <= 1'b1;
    end else begin
      AN <= an_next;
      D  <= d_next;
      DP <= dp_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scanner
// Directed bench for seven_seg_scanner with REFRESH_DIV=4, BLANK_CYC=2
// (24-cycle frame). Outputs are sampled on the falling edge; inputs change
// on the falling edge. Frame position p counts falling edges after reset
// release: p%6 in 0..1 is dead time, 2..5 shows digit p/6.
// Honours LEADING_ZERO_BLANK_EN for the leading-zero expectations.
// ---------------------------------------------------------------------------
module tb_seven_seg_scanner;

  localparam int RD    = 4;
  localparam int BC    = 2;
  localparam int FRAME = 4 * (RD + BC);

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b1100000;
  localparam logic [6:0] SC = 7'b0110001;
  localparam logic [6:0] SD = 7'b1000010;
  localparam logic [6:0] SE = 7'b0110000;
  localparam logic [6:0] SF = 7'b0111000;
  localparam logic [6:0] OFF = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits_i;
  logic [3:0]  dp_i;
  logic [3:0]  blank_i;
  logic [3:0]  AN;
  logic [6:0]  D;
  logic        DP;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .REFRESH_DIV (RD),
    .BLANK_CYC   (BC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .digits_i (digits_i),
    .dp_i     (dp_i),
    .blank_i  (blank_i),
    .AN       (AN),
    .D        (D),
    .DP       (DP)
  );

  // Hold reset for n falling edges, release on a falling edge.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Check n cycles of a frame from position 0. segs = {d3,d2,d1,d0}.
  // After checking position change_at, digits_i is set to new_digits.
  task automatic check_frame(input string name, input logic [27:0] segs,
                             input logic [3:0] blank, input logic [3:0] dp,
                             input int n, input int change_at,
                             input logic [15:0] new_digits);
    logic [3:0] exp_an;
    logic [6:0] exp_d;
    logic       exp_dp;
    int         s;
    for (int p = 0; p < n; p++) begin
      @(negedge clk);
      s = (p % (RD + BC) >= BC) ? p / (RD + BC) : -1;
      if (s < 0 || blank[s]) begin
        exp_an = 4'b1111;
        exp_d  = OFF;
        exp_dp = 1'b1;
      end else begin
        exp_an = ~(4'b0001 << s);
        exp_d  = segs[s*7 +: 7];
        exp_dp = ~dp[s];
      end
      checks++;
      if (AN !== exp_an || D !== exp_d || DP !== exp_dp) begin
        failures++;
        $display("FAIL %s p=%0d got AN=%b D=%b DP=%b expected AN=%b D=%b DP=%b",
                 name, p, AN, D, DP, exp_an, exp_d, exp_dp);
      end
      if (p == change_at) digits_i = new_digits;
    end
  endtask

  task automatic test_reset();
    int first_low;
    int low_len;
    digits_i = 16'h1234;
    dp_i     = 4'b0000;
    blank_i  = 4'b0000;
    rst_n    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (AN !== 4'b1111 || D !== OFF || DP !== 1'b1) begin
        failures++;
        $display("FAIL reset_hold k=%0d got AN=%b D=%b DP=%b expected 1111 1111111 1",
                 k, AN, D, DP);
      end
    end
    rst_n     = 1'b1;
    first_low = -1;
    low_len   = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (AN == 4'b1110) begin
        if (first_low < 0) first_low = k;
        low_len++;
      end
    end
    checks++;
    if (first_low != 2) begin
      failures++;
      $display("FAIL reset_first_an got=%0d expected=2", first_low);
    end
    checks++;
    if (low_len != RD) begin
      failures++;
      $display("FAIL reset_an_len got=%0d expected=%0d", low_len, RD);
    end
  endtask

  task automatic test_scan();
    digits_i = 16'h1234;
    dp_i     = 4'b0000;
    blank_i  = 4'b0000;
    do_reset(2);
    check_frame("scan_f0", {S1, S2, S3, S4}, 4'b0000, 4'b0000, FRAME, -1, 16'h1234);
    check_frame("scan_f1", {S1, S2, S3, S4}, 4'b0000, 4'b0000, FRAME, -1, 16'h1234);
  endtask

  task automatic test_tearing();
    digits_i = 16'h1234;
    dp_i     = 4'b0000;
    blank_i  = 4'b0000;
    do_reset(2);
    // Change while digit 1 is lit (positions 8..11).
    check_frame("tear_f0", {S1, S2, S3, S4}, 4'b0000, 4'b0000, FRAME, 9, 16'hABCD);
    check_frame("tear_f1", {SA, SB, SC, SD}, 4'b0000, 4'b0000, FRAME, -1, 16'hABCD);
  endtask

  task automatic test_blank_dp();
    digits_i = 16'h1234;
    dp_i     = 4'b0001;
    blank_i  = 4'b0100;
    do_reset(2);
    check_frame("blkdp_f0", {S1, S2, S3, S4}, 4'b0100, 4'b0001, FRAME, -1, 16'h1234);
    check_frame("blkdp_f1", {S1, S2, S3, S4}, 4'b0100, 4'b0001, FRAME, -1, 16'h1234);
    blank_i = 4'b0000;
    dp_i    = 4'b0000;
  endtask

  task automatic test_mid_reset();
    digits_i = 16'h1234;
    dp_i     = 4'b0000;
    blank_i  = 4'b0000;
    do_reset(2);
    // Positions 0..15: digit 2 lit at 14 and 15.
    check_frame("midrst_pre", {S1, S2, S3, S4}, 4'b0000, 4'b0000, 16, -1, 16'h1234);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (AN !== 4'b1111 || D !== OFF || DP !== 1'b1) begin
      failures++;
      $display("FAIL midrst_off got AN=%b D=%b DP=%b expected 1111 1111111 1", AN, D, DP);
    end
    rst_n = 1'b1;
    check_frame("midrst_post", {S1, S2, S3, S4}, 4'b0000, 4'b0000, FRAME, -1, 16'h1234);
  endtask

  task automatic test_back_to_back();
    digits_i = 16'h8F70;
    dp_i     = 4'b0000;
    blank_i  = 4'b0000;
    do_reset(2);
    // New value lands just before the next snapshot edge.
    check_frame("b2b_f0", {S8, SF, S7, S0}, 4'b0000, 4'b0000, FRAME, FRAME - 1, 16'hE6D9);
    check_frame("b2b_f1", {SE, S6, SD, S9}, 4'b0000, 4'b0000, FRAME, -1, 16'hE6D9);
  endtask

  task automatic test_leading_zero();
    digits_i = 16'h0005;
    dp_i     = 4'b0000;
    blank_i  = 4'b0000;
    do_reset(2);
`ifdef LEADING_ZERO_BLANK_EN
    check_frame("lzb", {S0, S0, S0, S5}, 4'b1110, 4'b0000, FRAME, -1, 16'h0005);
`else
    check_frame("lzb", {S0, S0, S0, S5}, 4'b0000, 4'b0000, FRAME, -1, 16'h0005);
`endif
  endtask

  initial begin
    rst_n    = 1'b0;
    digits_i = 16'h0000;
    dp_i     = 4'b0000;
    blank_i  = 4'b0000;
    test_reset();
    test_scan();
    test_tearing();
    test_blank_dp();
    test_mid_reset();
    test_back_to_back();
    test_leading_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
